// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation scheduler: selector encodings,
// datapath widths, scheduler state and per-opcode hold latency.
package alu_pkg;

  localparam int SEL_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [SEL_W-1:0] SEL_ADD = 5'd0;
  localparam logic [SEL_W-1:0] SEL_SUB = 5'd1;
  localparam logic [SEL_W-1:0] SEL_AND = 5'd2;
  localparam logic [SEL_W-1:0] SEL_OR  = 5'd3;
  localparam logic [SEL_W-1:0] SEL_XOR = 5'd4;
  localparam logic [SEL_W-1:0] SEL_NOT = 5'd5;
  localparam logic [SEL_W-1:0] SEL_SHL = 5'd6;
  localparam logic [SEL_W-1:0] SEL_SHR = 5'd7;
  localparam logic [SEL_W-1:0] SEL_SAR = 5'd8;
  localparam logic [SEL_W-1:0] SEL_ROL = 5'd9;
  localparam logic [SEL_W-1:0] SEL_ROR = 5'd10;
  localparam logic [SEL_W-1:0] SEL_MUL = 5'd11;
  localparam logic [SEL_W-1:0] SEL_DIV = 5'd12;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  // Number of cycles the ALU inputs must be held stable for a selector.
  function automatic int unsigned op_latency(input logic [SEL_W-1:0] sel,
                                             input int unsigned mul_cycles,
                                             input int unsigned div_cycles);
    case (sel)
      SEL_MUL: return mul_cycles;
      SEL_DIV: return div_cycles;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request/response channels of all requesters plus the shared ALU port.
// master = clients and ALU side, slave = the scheduler.
interface alu_op_scheduler_if
  import alu_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [SEL_W*NREQ-1:0]  req_sel_i;
  logic [DATA_W*NREQ-1:0] req_a_i;
  logic [DATA_W*NREQ-1:0] req_b_i;
  logic [NREQ-1:0]        req_carry_i;

  logic [NREQ-1:0]        resp_valid_o;
  logic [NREQ-1:0]        resp_ready_i;
  logic [DATA_W-1:0]      resp_data_o;
  logic                   resp_carry_o;
  logic                   resp_ovf_o;
  logic                   resp_err_o;

  logic [SEL_W-1:0]       alu_sel_o;
  logic [DATA_W-1:0]      alu_a_o;
  logic [DATA_W-1:0]      alu_b_o;
  logic                   alu_carry_o;
  logic [DATA_W-1:0]      alu_result_i;
  logic                   alu_carry_i;
  logic                   alu_ovf_i;

  modport master (
    output req_valid_i, req_sel_i, req_a_i, req_b_i, req_carry_i, resp_ready_i,
           alu_result_i, alu_carry_i, alu_ovf_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_carry_o, resp_ovf_o,
           resp_err_o, alu_sel_o, alu_a_o, alu_b_o, alu_carry_o
  );

  modport slave (
    input  req_valid_i, req_sel_i, req_a_i, req_b_i, req_carry_i, resp_ready_i,
           alu_result_i, alu_carry_i, alu_ovf_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_carry_o, resp_ovf_o,
           resp_err_o, alu_sel_o, alu_a_o, alu_b_o, alu_carry_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  int   k;
  logic found;

  // NOTE: every output gets a default before the search, otherwise paths
  // with no request would leave them unassigned and infer latches.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = ($clog2(NREQ))'(k);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Time-shares one ALU between NREQ requesters: round-robin accept, hold the
// operands for the opcode's latency, then return the captured result.
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int MAX_SEL    = 12
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_op_scheduler_if.slave bus
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, gnt_q, arb_idx;
  logic [NREQ-1:0]   arb_grant;
  logic [CNT_W-1:0]  cnt_q, lat_m1;

  logic [SEL_W-1:0]  alu_sel_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              alu_carry_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_carry_q, resp_ovf_q, resp_err_q;

  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] req_a, req_b;
  logic              req_cin, legal, accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (bus.req_valid_i),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    req_sel = bus.req_sel_i[int'(arb_idx)*SEL_W +: SEL_W];
    req_a   = bus.req_a_i[int'(arb_idx)*DATA_W +: DATA_W];
    req_b   = bus.req_b_i[int'(arb_idx)*DATA_W +: DATA_W];
    req_cin = bus.req_carry_i[arb_idx];
    legal   = int'(32'(req_sel)) <= MAX_SEL;
    lat_m1  = CNT_W'(op_latency(req_sel, MUL_CYCLES, DIV_CYCLES) - 1);
    accept  = (state_q == IDLE) && (|arb_grant);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = legal ? EXEC : RESP;
      EXEC: if (cnt_q == '0) state_d = RESP;
      RESP: if (bus.resp_ready_i[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register here sees
  // the pre-edge value of every other one regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NREQ - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
      alu_sel_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_carry_q  <= 1'b0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      resp_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          ptr_q <= arb_idx;
          gnt_q <= arb_idx;
          if (legal) begin
            // The ALU drive registers double as the operand latch; an illegal
            // request never reaches them, so the ALU inputs stay untouched.
            alu_sel_q   <= req_sel;
            alu_a_q     <= req_a;
            alu_b_q     <= req_b;
            alu_carry_q <= req_cin;
            cnt_q       <= lat_m1;
          end else begin
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_ovf_q   <= 1'b0;
            resp_err_q   <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            resp_data_q  <= bus.alu_result_i;
            resp_carry_q <= bus.alu_carry_i;
            resp_ovf_q   <= bus.alu_ovf_i;
            resp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is gated by reset so nothing looks accepted while reset is held.
  assign bus.req_ready_o  = (state_q == IDLE && !rst_i) ? arb_grant : '0;
  assign bus.resp_valid_o = (state_q == RESP) ? (ONE << gnt_q) : '0;
  assign bus.resp_data_o  = resp_data_q;
  assign bus.resp_carry_o = resp_carry_q;
  assign bus.resp_ovf_o   = resp_ovf_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.alu_sel_o    = alu_sel_q;
  assign bus.alu_a_o      = alu_a_q;
  assign bus.alu_b_o      = alu_b_q;
  assign bus.alu_carry_o  = alu_carry_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a small behavioural ALU attached.
module tb_alu_op_scheduler;
  import alu_pkg::*;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_op_scheduler_if #(.NREQ(NREQ)) bus ();

  alu_op_scheduler #(
    .NREQ(NREQ), .MUL_CYCLES(4), .DIV_CYCLES(8), .MAX_SEL(12)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Behavioural ALU: add with carry/overflow, sub, mul, div.
  logic [32:0] sum;
  always_comb begin
    sum              = '0;
    bus.alu_result_i = '0;
    bus.alu_carry_i  = 1'b0;
    bus.alu_ovf_i    = 1'b0;
    case (bus.alu_sel_o)
      SEL_ADD: begin
        sum              = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o} + {32'b0, bus.alu_carry_o};
        bus.alu_result_i = sum[31:0];
        bus.alu_carry_i  = sum[32];
        bus.alu_ovf_i    = (bus.alu_a_o[31] == bus.alu_b_o[31]) && (sum[31] != bus.alu_a_o[31]);
      end
      SEL_SUB: bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
      SEL_MUL: bus.alu_result_i = bus.alu_a_o * bus.alu_b_o;
      SEL_DIV: bus.alu_result_i = (bus.alu_b_o == '0) ? '1 : bus.alu_a_o / bus.alu_b_o;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid_i  = '0;
    bus.req_sel_i    = '0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.req_carry_i  = '0;
    bus.resp_ready_i = '0;
  endtask

  task automatic set_req(input int k, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
    bus.req_sel_i[k*5 +: 5]  = sel;
    bus.req_a_i[k*32 +: 32]  = a;
    bus.req_b_i[k*32 +: 32]  = b;
    bus.req_carry_i[k]       = cin;
    bus.req_valid_i[k]       = 1'b1;
  endtask

  // Reset with a pending request to show ready stays low while reset is held.
  task automatic do_reset();
    clear_inputs();
    bus.req_valid_i[0] = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_ready",  64'(bus.req_ready_o), 64'(0));
    check("rst_rvalid", 64'(bus.resp_valid_o), 64'(0));
    check("rst_data",   64'(bus.resp_data_o), 64'(0));
    check("rst_err",    64'(bus.resp_err_o), 64'(0));
    check("rst_alusel", 64'(bus.alu_sel_o), 64'(0));
    check("rst_alua",   64'(bus.alu_a_o), 64'(0));
    bus.req_valid_i = '0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full transaction on requester k; latency counted from the ready cycle.
  task automatic run_op(input int k, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic [31:0] exp_data,
                        input logic exp_err, input logic [1:0] exp_flags, input int exp_lat,
                        input logic [4:0] exp_alu_sel, input string tag);
    int n;
    int cyc;
    set_req(k, sel, a, b, cin);
    #1;
    n = 0;
    while (!bus.req_ready_o[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, 64'(bus.req_ready_o), 64'(1) << k);
    @(posedge clk); #1;
    bus.req_valid_i[k] = 1'b0;
    cyc = 1;
    while (bus.resp_valid_o == '0 && cyc < 40) begin
      check({tag, "_hold"}, 64'(bus.alu_sel_o), 64'(exp_alu_sel));
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"},    64'(cyc), 64'(exp_lat + 1));
    check({tag, "_rvalid"}, 64'(bus.resp_valid_o), 64'(1) << k);
    check({tag, "_data"},   64'(bus.resp_data_o), 64'(exp_data));
    check({tag, "_err"},    64'(bus.resp_err_o), 64'(exp_err));
    check({tag, "_flags"},  64'({bus.resp_carry_o, bus.resp_ovf_o}), 64'(exp_flags));
    check({tag, "_alusel"}, 64'(bus.alu_sel_o), 64'(exp_alu_sel));
    bus.resp_ready_i[k] = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = '0;
    check({tag, "_done"}, 64'(bus.resp_valid_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc;
    int g;
    logic [31:0] sums [2];
    sums[0] = 32'd3;
    sums[1] = 32'd30;

    do_reset();

    // Single ops, including carry-out and signed overflow corners.
    run_op(0, SEL_ADD, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 2'b00, 1, SEL_ADD, "add0");
    run_op(1, SEL_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0, 2'b10, 1, SEL_ADD, "addc");
    run_op(0, SEL_ADD, 32'h7FFF_FFFF, 32'd0, 1'b1, 32'h8000_0000, 1'b0, 2'b01, 1, SEL_ADD, "addv");

    // Contention: both requesters hold valid, grants must alternate 0,1,0,1.
    do_reset();
    set_req(0, SEL_ADD, 32'd1, 32'd2, 1'b0);
    set_req(1, SEL_ADD, 32'd10, 32'd20, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      check("rr_ready", 64'(bus.req_ready_o), 64'(1) << g);
      @(posedge clk); #1;
      cyc = 1;
      while (bus.resp_valid_o == '0 && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("rr_rvalid", 64'(bus.resp_valid_o), 64'(1) << g);
      check("rr_data",   64'(bus.resp_data_o), 64'(sums[g]));
      bus.resp_ready_i[g] = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready_i = '0;
    end
    bus.req_valid_i = '0;

    // Multi-cycle multiply, then an illegal selector that must skip EXEC.
    run_op(0, SEL_MUL, 32'd6, 32'd7, 1'b0, 32'd42, 1'b0, 2'b00, 4, SEL_MUL, "mul");
    run_op(1, 5'd20, 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 2'b00, 0, SEL_MUL, "ill");
    check("ill_alua", 64'(bus.alu_a_o), 64'(6));

    // Backpressure: response held 10 cycles while requester 1 waits.
    set_req(0, SEL_SUB, 32'd50, 32'd8, 1'b0);
    set_req(1, SEL_ADD, 32'd1, 32'd1, 1'b0);
    #1;
    check("bp_ready0", 64'(bus.req_ready_o), 64'(1));
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    cyc = 1;
    while (bus.resp_valid_o == '0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_lat", 64'(cyc), 64'(2));
    bus.resp_ready_i[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rvalid", 64'(bus.resp_valid_o), 64'(1));
      check("bp_data",   64'(bus.resp_data_o), 64'(42));
      check("bp_ready",  64'(bus.req_ready_o), 64'(0));
      @(posedge clk); #1;
    end
    bus.resp_ready_i = 2'b01;
    @(posedge clk); #1;
    bus.resp_ready_i = '0;
    check("bp_release", 64'(bus.resp_valid_o), 64'(0));
    check("bp_next",    64'(bus.req_ready_o), 64'(2));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    cyc = 1;
    while (bus.resp_valid_o == '0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_r1valid", 64'(bus.resp_valid_o), 64'(2));
    check("bp_r1data",  64'(bus.resp_data_o), 64'(2));
    bus.resp_ready_i = 2'b10;
    @(posedge clk); #1;
    bus.resp_ready_i = '0;

    // Reset in the third EXEC cycle of a divide granted to requester 0.
    set_req(0, SEL_DIV, 32'd100, 32'd7, 1'b0);
    #1;
    check("div_ready", 64'(bus.req_ready_o), 64'(1));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("div_busy", 64'(bus.alu_sel_o), 64'(SEL_DIV));
    rst = 1'b1;
    #1;
    check("abort_rvalid", 64'(bus.resp_valid_o), 64'(0));
    check("abort_alusel", 64'(bus.alu_sel_o), 64'(0));
    check("abort_alua",   64'(bus.alu_a_o), 64'(0));
    check("abort_data",   64'(bus.resp_data_o), 64'(0));
    @(posedge clk); #1;
    check("abort_hold", 64'(bus.resp_valid_o), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    set_req(0, SEL_DIV, 32'd100, 32'd7, 1'b0);
    set_req(1, SEL_ADD, 32'd3, 32'd4, 1'b0);
    #1;
    check("post_rr", 64'(bus.req_ready_o), 64'(1));
    run_op(0, SEL_DIV, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 2'b00, 8, SEL_DIV, "div");
    run_op(1, SEL_ADD, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 2'b00, 1, SEL_ADD, "post1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one ALU datapath (5-bit selector, 32-bit operands, carry-in; result, carry-out and overflow back) between NREQ requesters.
- Round-robin arbitration with a valid/ready request channel and a valid/ready response channel per requester.
- Registers operands and holds the ALU inputs stable for a per-opcode number of cycles (multi-cycle multiply/divide), then captures and returns the result.
- Sits between the frequency-counter control logic (and any other clients) and the ALU.

Parameters:
- NREQ, 2, number of requesters (2..4).
- MUL_CYCLES, 4, cycles ALU inputs are held for selector 11 (multiply), min 1.
- DIV_CYCLES, 8, cycles ALU inputs are held for selector 12 (divide), min 1.
- MAX_SEL, 12, highest legal selector value.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NREQ  request valid, one bit per requester.
- req_ready_o  out  NREQ  request accepted this cycle.
- req_sel_i  in  5*NREQ  ALU selector; requester k uses bits [5k+4:5k].
- req_a_i  in  32*NREQ  operand A per requester.
- req_b_i  in  32*NREQ  operand B per requester.
- req_carry_i  in  NREQ  carry-in per requester.
- resp_valid_o  out  NREQ  response valid; one-hot or zero.
- resp_ready_i  in  NREQ  response accepted.
- resp_data_o  out  32  captured result, shared by all requesters.
- resp_carry_o  out  1  captured carry-out.
- resp_ovf_o  out  1  captured overflow.
- resp_err_o  out  1  illegal selector flag.
- alu_sel_o  out  5  to ALU selector.
- alu_a_o  out  32  to ALU operand A.
- alu_b_o  out  32  to ALU operand B.
- alu_carry_o  out  1  to ALU carry-in.
- alu_result_i  in  32  from ALU.
- alu_carry_i  in  1  from ALU carry-out.
- alu_ovf_i  in  1  from ALU overflow.

Behaviour:
- Reset values (asynchronous):
  - State IDLE; all req_ready_o, resp_valid_o, resp_data_o, resp_carry_o, resp_ovf_o, resp_err_o, alu_* outputs are 0.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - Cycle counter = 0.
- IDLE:
  - grant = first requester with req_valid_i set, searching from pointer+1 upward with wrap.
  - req_ready_o[grant] = 1 combinationally; all other ready bits are 0. Ready depends on valid; valid must never depend on ready.
  - On the accept edge: latch selector, A, B, carry and grant index; pointer <= grant.
  - Legal selector (<= MAX_SEL): go to EXEC, counter <= lat-1. lat = MUL_CYCLES for 11, DIV_CYCLES for 12, otherwise 1.
  - Illegal selector: skip EXEC, go directly to RESP with data, carry and ovf = 0 and err = 1.
- EXEC:
  - alu_* outputs driven from the latched registers and held constant for every EXEC cycle. In all other states they hold their last values (no toggling).
  - Counter decrements each cycle.
  - On the cycle counter == 0: capture alu_result_i, alu_carry_i and alu_ovf_i into the resp_* registers, set err = 0, go to RESP.
  - A 1-cycle op spends exactly one cycle in EXEC. Accept-to-resp_valid latency is lat+1 cycles.
- RESP:
  - resp_valid_o[grant] = 1; resp_* held stable.
  - When resp_ready_i[grant] = 1: deassert valid and return to IDLE. The next grant can occur on the following cycle.
  - resp_ready_i bits of non-granted requesters are ignored.
- Only one operation is in flight at a time. req_ready_o is 0 outside IDLE.
- Simultaneous requests: strict round-robin; a continuously requesting requester cannot be starved past NREQ-1 other grants.
- A requester dropping valid without a handshake has no effect (nothing is latched).
- Reset asserted mid-EXEC or mid-RESP aborts the operation. The result is discarded and all outputs return to their reset values immediately.

Decomposition:
- Shared package alu_pkg:
  - selector constants SEL_ADD=0 … SEL_DIV=12, SEL_W=5, DATA_W=32;
  - the state enum {IDLE, EXEC, RESP}.
- One natural sub-module, rr_arbiter: parameter NREQ; inputs req vector and pointer; output one-hot grant and grant index. Purely combinational.

Test Plan:
- Reset then single add: req0 sel=0, A=5, B=7, carry=0; ALU model returns A+B+cin -> resp_valid_o=01 two cycles after accept, data=12, err=0.
- Contention: both requesters valid with adds after reset -> grant order 0,1,0,1 over four operations; each requester sees its own sum.
- Multiply latency: sel=11, A=6, B=7 with MUL_CYCLES=4 -> alu_sel_o=11 held 4 cycles; resp_valid 5 cycles after accept, data=42.
- Illegal selector: sel=20 -> no EXEC cycle; resp_valid next cycle with err=1, data=0; alu_sel_o unchanged.
- Response backpressure: resp_ready_i low for 10 cycles -> resp_data_o and resp_valid_o stable throughout; req1 valid meanwhile sees req_ready_o=0 until the handshake completes.
- Reset during a divide (cycle 3 of 8) -> outputs at reset values on the next edge; a new request is afterwards served with correct result and arbitration restarts at requester 0.
